// File: rtl/capture_scheduler.sv
// Ping-pong capture sequencer: restarts the ADC capture block for each frame, alternates the
// write bank, offers full banks to the consumer oldest-first, and flags stalls and hung captures.
module capture_scheduler #(
    parameter int unsigned TIMEOUT_W   = 20,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned FRAME_W     = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               continuous,
    input  logic               stop,
    output logic               cap_rst,
    input  logic               cap_standby,
    output logic               wr_bank,
    output logic               rd_valid,
    output logic               rd_bank,
    input  logic               rd_ack,
    output logic               busy,
    output logic               overrun,
    output logic               timeout_err,
    input  logic               clr_flags,
    output logic [FRAME_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        StIdle, StArm, StWaitLo, StCapture, StDone, StStall
    } state_e;

    state_e               state_q, state_d;
    logic                 cont_q, cont_d;
    logic                 stop_q, stop_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [1:0]           bank_full_q, bank_full_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 cap_rst_q, cap_rst_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cont_d      = cont_q;
        stop_d      = stop_q;
        wr_bank_d   = wr_bank_q;
        bank_full_d = bank_full_q;
        frame_d     = frame_q;
        wd_d        = wd_q;
        // A new set in the same cycle overrides the clear below.
        overrun_d   = overrun_q & ~clr_flags;
        timeout_d   = timeout_q & ~clr_flags;

        if (rd_ack && (bank_full_q != 2'b00)) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        if ((state_q != StIdle) && stop) begin
            stop_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StArm;
                    cont_d  = continuous;
                    stop_d  = 1'b0;
                end
            end
            StArm: begin
                wd_d    = '0;
                state_d = StWaitLo;
            end
            StWaitLo, StCapture: begin
                wd_d = wd_q + TIMEOUT_W'(1);
                if (wd_q == TIMEOUT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else if ((state_q == StWaitLo) && !cap_standby) begin
                    state_d = StCapture;
                end else if ((state_q == StCapture) && cap_standby) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bank_full_d[wr_bank_q] = 1'b1;
                frame_d                = frame_q + FRAME_W'(1);
                wr_bank_d              = ~wr_bank_q;
                if (!cont_q || stop_q) begin
                    state_d = StIdle;
                end else if (bank_full_d[wr_bank_d]) begin
                    state_d   = StStall;
                    overrun_d = 1'b1;
                end else begin
                    state_d = StArm;
                end
            end
            StStall: begin
                if (stop_q) begin
                    state_d = StIdle;
                end else if (!bank_full_q[wr_bank_q]) begin
                    state_d = StArm;
                end
            end
            default: state_d = StIdle;
        endcase

        // Oldest full bank is read first; when both are full it is the one that was full before.
        unique case (bank_full_d)
            2'b01:   rd_bank_d = 1'b0;
            2'b10:   rd_bank_d = 1'b1;
            2'b11:   rd_bank_d = (bank_full_q == 2'b10) ? 1'b1 :
                                 (bank_full_q == 2'b01) ? 1'b0 : rd_bank_q;
            default: rd_bank_d = rd_bank_q;
        endcase

        cap_rst_d = (state_d == StArm);
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            cont_q      <= 1'b0;
            stop_q      <= 1'b0;
            wr_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
            rd_bank_q   <= 1'b0;
            frame_q     <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
            cap_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cont_q      <= cont_d;
            stop_q      <= stop_d;
            wr_bank_q   <= wr_bank_d;
            bank_full_q <= bank_full_d;
            rd_bank_q   <= rd_bank_d;
            frame_q     <= frame_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
            cap_rst_q   <= cap_rst_d;
            busy_q      <= busy_d;
        end
    end

    assign cap_rst     = cap_rst_q;
    assign wr_bank     = wr_bank_q;
    assign rd_valid    = |bank_full_q;
    assign rd_bank     = rd_bank_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
    assign frame_cnt   = frame_q;

endmodule
